mdu_unit: RTL and testbench

MDU_UNIT -- requirements
Module: mdu_unit

---
 rtl/mdu_pkg.sv | 32 +++
 rtl/mdu_unit.sv | 186 ++++++++++++++++++
 tb/tb_mdu_unit.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: operation codes, FSM state encodings and small arithmetic
// helpers shared by the multiply/divide unit.
package mdu_pkg;

  // Operation codes carried on mdu_op.
  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;
  localparam logic [2:0] MDU_MADD  = 3'd6;
  localparam logic [2:0] MDU_MSUB  = 3'd7;

  // FSM state encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  // Two's-complement negate when neg is set, pass through otherwise.
  // Used both to take magnitudes and to re-apply signs in the divider.
  function automatic logic [31:0] mdu_cond_neg(input logic [31:0] v, input logic neg);
    logic [31:0] r;
    if (neg) begin
      r = 32'd0 - v;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit owning the HI/LO registers.
// Operands are latched at acceptance, busy is held for a fixed number of
// cycles, and HI/LO are written on the edge where busy falls.
// Optional feature: define MDU_MADD_EN to enable MADD/MSUB (ops 6/7);
// without it those ops are ignored.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        req,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

`ifdef MDU_MADD_EN
  localparam logic MADD_EN = 1'b1;
`else
  localparam logic MADD_EN = 1'b0;
`endif

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic [1:0]  state_r;
  logic [3:0]  cnt_r;
  logic        busy_r;
  logic [2:0]  op_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  logic        accept_s;
  logic        is_mul_s;
  logic        is_div_s;
  logic        is_mthi_s;
  logic        is_mtlo_s;

  logic [63:0] smul_s;
  logic [63:0] umul_s;
  logic        neg_a_s;
  logic        neg_b_s;
  logic [31:0] ua_s;
  logic [31:0] ub_s;
  logic [31:0] uq_s;
  logic [31:0] ur_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;

  logic        res_wr_s;
  logic [31:0] res_hi_s;
  logic [31:0] res_lo_s;

  assign accept_s = start & ~req & ~busy_r;

  // Classify the incoming op; MADD/MSUB only count as multiplies when enabled.
  always_comb begin
    is_mul_s  = 1'b0;
    is_div_s  = 1'b0;
    is_mthi_s = 1'b0;
    is_mtlo_s = 1'b0;
    case (mdu_op)
      MDU_MULT, MDU_MULTU: is_mul_s  = 1'b1;
      MDU_DIV, MDU_DIVU:   is_div_s  = 1'b1;
      MDU_MTHI:            is_mthi_s = 1'b1;
      MDU_MTLO:            is_mtlo_s = 1'b1;
      MDU_MADD, MDU_MSUB:  is_mul_s  = MADD_EN;
      default:             is_mul_s  = 1'b0;
    endcase
  end

  // Products from the latched operands; the signed form also feeds MADD/MSUB.
  assign smul_s = $signed({{32{a_r[31]}}, a_r}) * $signed({{32{b_r[31]}}, b_r});
  assign umul_s = {32'd0, a_r} * {32'd0, b_r};

  // Divide on magnitudes, then restore signs; this also makes
  // 0x80000000 / -1 fall out as quotient 0x80000000, remainder 0.
  always_comb begin
    neg_a_s = (op_r == MDU_DIV) & a_r[31];
    neg_b_s = (op_r == MDU_DIV) & b_r[31];
    ua_s    = mdu_cond_neg(a_r, neg_a_s);
    ub_s    = mdu_cond_neg(b_r, neg_b_s);
    if (ub_s == 32'd0) begin
      uq_s = 32'd0;
      ur_s = 32'd0;
    end else begin
      uq_s = ua_s / ub_s;
      ur_s = ua_s % ub_s;
    end
    quo_s = mdu_cond_neg(uq_s, neg_a_s ^ neg_b_s);
    rem_s = mdu_cond_neg(ur_s, neg_a_s);
  end

  // Select the HI/LO value to commit when the in-flight op finishes.
  always_comb begin
    res_wr_s = 1'b0;
    res_hi_s = hi_r;
    res_lo_s = lo_r;
    case (op_r)
      MDU_MULT: begin
        res_wr_s             = 1'b1;
        {res_hi_s, res_lo_s} = smul_s;
      end
      MDU_MULTU: begin
        res_wr_s             = 1'b1;
        {res_hi_s, res_lo_s} = umul_s;
      end
      MDU_DIV, MDU_DIVU: begin
        // Divide by zero leaves HI/LO untouched.
        res_wr_s = (b_r != 32'd0);
        res_hi_s = rem_s;
        res_lo_s = quo_s;
      end
      MDU_MADD: begin
        // HI/LO cannot change while busy, so they still hold the acceptance values.
        res_wr_s             = 1'b1;
        {res_hi_s, res_lo_s} = {hi_r, lo_r} + smul_s;
      end
      MDU_MSUB: begin
        res_wr_s             = 1'b1;
        {res_hi_s, res_lo_s} = {hi_r, lo_r} - smul_s;
      end
      default: res_wr_s = 1'b0;
    endcase
  end

  // FSM, cycle counter, operand latches and the architectural HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      busy_r  <= 1'b0;
      op_r    <= 3'd0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
    end else if (state_r != ST_IDLE) begin
      if (cnt_r == 4'd1) begin
        state_r <= ST_IDLE;
        cnt_r   <= 4'd0;
        busy_r  <= 1'b0;
        if (res_wr_s) begin
          hi_r <= res_hi_s;
          lo_r <= res_lo_s;
        end
      end else begin
        cnt_r <= cnt_r - 4'd1;
      end
    end else if (accept_s) begin
      if (is_mul_s) begin
        state_r <= ST_MUL;
        cnt_r   <= MULT_LOAD;
        busy_r  <= 1'b1;
        op_r    <= mdu_op;
        a_r     <= rs_val;
        b_r     <= rt_val;
      end else if (is_div_s) begin
        state_r <= ST_DIV;
        cnt_r   <= DIV_LOAD;
        busy_r  <= 1'b1;
        op_r    <= mdu_op;
        a_r     <= rs_val;
        b_r     <= rt_val;
      end else if (is_mthi_s) begin
        hi_r <= rs_val;
      end else if (is_mtlo_s) begin
        lo_r <= rs_val;
      end
    end
  end

  assign busy = busy_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: randomized self-checking bench for mdu_unit against a
// 64-bit arithmetic reference model of HI/LO.
module tb_mdu_unit;
  import mdu_pkg::*;

`ifdef MDU_MADD_EN
  localparam bit MADD_ON = 1'b1;
`else
  localparam bit MADD_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        req;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
    .rs_val(rs_val), .rt_val(rt_val), .req(req),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Expected busy length per op at default parameters.
  function automatic int exp_cycles(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: return 5;
      3'd2, 3'd3: return 10;
      3'd6, 3'd7: return MADD_ON ? 5 : 0;
      default:    return 0;
    endcase
  endfunction

  // Reference model: HI/LO after an accepted op, plain 64-bit arithmetic.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p, q, r, acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; hi_m = p[63:32]; lo_m = p[31:0]; end
      3'd2: if (b != 32'd0) begin q = sa / sb; r = sa % sb; lo_m = q[31:0]; hi_m = r[31:0]; end
      3'd3: if (b != 32'd0) begin lo_m = a / b; hi_m = a % b; end
      3'd4: hi_m = a;
      3'd5: lo_m = a;
      3'd6: if (MADD_ON) begin acc = {hi_m, lo_m} + 64'(sa * sb); hi_m = acc[63:32]; lo_m = acc[31:0]; end
      default: if (MADD_ON) begin acc = {hi_m, lo_m} - 64'(sa * sb); hi_m = acc[63:32]; lo_m = acc[31:0]; end
    endcase
  endtask

  // Issue one op, scramble operands while busy, count busy cycles (bounded).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic hold_req, output int cycles);
    @(negedge clk);
    start = 1'b1; mdu_op = op; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0; rs_val = $urandom; rt_val = $urandom; req = hold_req;
    cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
    req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; req = 1'b0; mdu_op = 3'd0; rs_val = 32'd0; rt_val = 32'd0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
    reset = 1'b0;
    hi_m = 32'd0; lo_m = 32'd0;
  endtask

  task automatic test_mult();
    int cyc;
    logic [31:0] a, b;
    logic [2:0] op;
    run_op(MDU_MULT, 32'hFFFFFFFE, 32'd3, 1'b0, cyc);
    checks++; if (cyc != 5) begin errors++; $display("FAIL mult_dir_cycles got %0d want 5", cyc); end
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
      errors++; $display("FAIL mult_dir got %h:%h want ffffffff:fffffffa", hi, lo); end
    model(MDU_MULT, 32'hFFFFFFFE, 32'd3);
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom; op = (i % 2 == 0) ? MDU_MULT : MDU_MULTU;
      run_op(op, a, b, 1'b0, cyc);
      model(op, a, b);
      checks++; if (cyc != 5) begin errors++; $display("FAIL mult_cycles op %0d got %0d want 5", op, cyc); end
      checks++; if (hi !== hi_m || lo !== lo_m) begin
        errors++; $display("FAIL mult op %0d %h*%h got %h:%h want %h:%h", op, a, b, hi, lo, hi_m, lo_m); end
    end
  endtask

  task automatic test_div();
    int cyc;
    logic [31:0] a, b;
    logic [2:0] op;
    run_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, cyc);
    checks++; if (cyc != 10) begin errors++; $display("FAIL div_dir_cycles got %0d want 10", cyc); end
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      errors++; $display("FAIL div_dir got %h:%h want ffffffff:fffffffd", hi, lo); end
    model(MDU_DIV, 32'hFFFFFFF9, 32'd2);
    run_op(MDU_DIVU, 32'd7, 32'd0, 1'b0, cyc);
    checks++; if (cyc != 10) begin errors++; $display("FAIL divzero_cycles got %0d want 10", cyc); end
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      errors++; $display("FAIL divzero got %h:%h want unchanged ffffffff:fffffffd", hi, lo); end
    run_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, cyc);
    checks++; if (hi !== 32'd0 || lo !== 32'h80000000) begin
      errors++; $display("FAIL div_ovf got %h:%h want 00000000:80000000", hi, lo); end
    model(MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
    for (int i = 0; i < 10; i++) begin
      a = $urandom; op = (i % 2 == 0) ? MDU_DIV : MDU_DIVU;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 300)));
      if (($urandom_range(0, 1)) == 1) b = 32'd0 - b;
      run_op(op, a, b, 1'b0, cyc);
      model(op, a, b);
      checks++; if (cyc != 10) begin errors++; $display("FAIL div_cycles op %0d got %0d want 10", op, cyc); end
      checks++; if (hi !== hi_m || lo !== lo_m) begin
        errors++; $display("FAIL div op %0d %h/%h got %h:%h want %h:%h", op, a, b, hi, lo, hi_m, lo_m); end
    end
  endtask

  task automatic test_mthi_req();
    int cyc;
    run_op(MDU_MTHI, 32'h12345678, 32'd0, 1'b0, cyc);
    model(MDU_MTHI, 32'h12345678, 32'd0);
    checks++; if (cyc != 0) begin errors++; $display("FAIL mthi_busy got %0d cycles want 0", cyc); end
    checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL mthi got %h want 12345678", hi); end
    run_op(MDU_MTLO, 32'h0BADF00D, 32'd0, 1'b0, cyc);
    model(MDU_MTLO, 32'h0BADF00D, 32'd0);
    checks++; if (cyc != 0 || lo !== lo_m) begin
      errors++; $display("FAIL mtlo got %h cycles %0d want %h cycles 0", lo, cyc, lo_m); end
    req = 1'b1;
    run_op(MDU_MTHI, 32'hDEADBEEF, 32'd0, 1'b0, cyc);
    checks++; if (hi !== hi_m) begin errors++; $display("FAIL req_mthi got %h want %h", hi, hi_m); end
    req = 1'b1;
    run_op(MDU_MULT, 32'd9, 32'd9, 1'b0, cyc);
    checks++; if (cyc != 0 || lo !== lo_m) begin
      errors++; $display("FAIL req_mult cycles %0d lo %h want 0 and %h", cyc, lo, lo_m); end
    run_op(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, cyc);
    model(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checks++; if (cyc != 5 || hi !== hi_m || lo !== lo_m) begin
      errors++; $display("FAIL req_inflight cycles %0d got %h:%h want 5 %h:%h", cyc, hi, lo, hi_m, lo_m); end
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    run_op(MDU_MTHI, 32'hA5A5A5A5, 32'd0, 1'b0, cyc);
    run_op(MDU_MTLO, 32'h5A5A5A5A, 32'd0, 1'b0, cyc);
    @(negedge clk);
    start = 1'b1; mdu_op = MDU_DIV; rs_val = 32'd100; rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL midrst_hilo got %h:%h want 0:0", hi, lo); end
    @(negedge clk);
    reset = 1'b0;
    hi_m = 32'd0; lo_m = 32'd0;
    repeat (12) @(negedge clk);
    checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL midrst_discard busy %b got %h:%h want 0 0:0", busy, hi, lo); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [31:0] a1, b1, a2, b2;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    @(negedge clk);
    start = 1'b1; mdu_op = MDU_MULT; rs_val = a1; rt_val = b1;
    @(negedge clk);
    rs_val = a2; rt_val = b2;
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin cyc++; @(negedge clk); end
    model(MDU_MULT, a1, b1);
    checks++; if (cyc != 5) begin errors++; $display("FAIL b2b_first_cycles got %0d want 5", cyc); end
    checks++; if (hi !== hi_m || lo !== lo_m) begin
      errors++; $display("FAIL b2b_first got %h:%h want %h:%h", hi, lo, hi_m, lo_m); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy got %b want 1", busy); end
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin cyc++; @(negedge clk); end
    model(MDU_MULT, a2, b2);
    checks++; if (cyc != 5 || hi !== hi_m || lo !== lo_m) begin
      errors++; $display("FAIL b2b_second cycles %0d got %h:%h want 5 %h:%h", cyc, hi, lo, hi_m, lo_m); end
  endtask

  task automatic test_madd();
    int cyc;
    logic [31:0] a, b;
    run_op(MDU_MTHI, 32'd0, 32'd0, 1'b0, cyc); model(MDU_MTHI, 32'd0, 32'd0);
    run_op(MDU_MTLO, 32'd5, 32'd0, 1'b0, cyc); model(MDU_MTLO, 32'd5, 32'd0);
    run_op(MDU_MADD, 32'd2, 32'd3, 1'b0, cyc);
    model(MDU_MADD, 32'd2, 32'd3);
    checks++; if (cyc != exp_cycles(MDU_MADD)) begin
      errors++; $display("FAIL madd_cycles got %0d want %0d", cyc, exp_cycles(MDU_MADD)); end
    checks++; if (lo !== (MADD_ON ? 32'd11 : 32'd5) || hi !== 32'd0) begin
      errors++; $display("FAIL madd_dir got %h:%h want 0:%0d", hi, lo, MADD_ON ? 11 : 5); end
    a = $urandom; b = $urandom;
    run_op(MDU_MSUB, a, b, 1'b0, cyc);
    model(MDU_MSUB, a, b);
    checks++; if (cyc != exp_cycles(MDU_MSUB) || hi !== hi_m || lo !== lo_m) begin
      errors++; $display("FAIL msub cycles %0d got %h:%h want %0d %h:%h", cyc, hi, lo, exp_cycles(MDU_MSUB), hi_m, lo_m); end
  endtask

  task automatic test_random();
    int cyc;
    logic [31:0] a, b;
    logic [2:0] op;
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      run_op(op, a, b, 1'b0, cyc);
      model(op, a, b);
      checks++; if (cyc != exp_cycles(op) || hi !== hi_m || lo !== lo_m) begin
        errors++; $display("FAIL rand op %0d a %h b %h cycles %0d got %h:%h want %0d %h:%h",
                           op, a, b, cyc, hi, lo, exp_cycles(op), hi_m, lo_m); end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_req();
    test_reset_mid_op();
    test_back_to_back();
    test_madd();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
